instruction_fetcher: RTL and testbench
======================================

// Module: instruction_fetcher
// PURPOSE
//   Per-core instruction fetch stage, directly upstream of the scheduler.
//   - When the scheduler enters FETCH, supplies the instruction at current_pc.
//   - A small direct-mapped instruction cache (one instruction per line) is looked up first.
//   - On a miss, runs a valid/ready read on the program-memory port and fills the cache.
//   - Reports progress on fetcher_state; the scheduler leaves FETCH when it reads FETCHED.
// PARAMETERS
//   PROGRAM_MEM_ADDR_BITS  8   program address / PC width
//   PROGRAM_MEM_DATA_BITS  16  instruction width
//   CACHE_LINES            8   number of cache lines; power of two, >= 2
//   COUNTER_BITS           16  width of the hit and miss performance counters
// PORTS
//   clk               in   1      clock; all logic is on the rising edge
//   reset             in   1      synchronous, active-high
//   core_state        in   3      scheduler state (FETCH=3'b001, DECODE=3'b010)
//   current_pc        in   ADDR   PC to fetch
//   mem_read_valid    out  1      program-memory read request
//   mem_read_address  out  ADDR   read address
//   mem_read_ready    in   1      read data valid this cycle
//   mem_read_data     in   DATA   returned instruction
//   fetcher_state     out  3      IDLE=3'b000, FETCHING=3'b001, FETCHED=3'b010
//   instruction       out  DATA   fetched instruction; valid while in FETCHED
//   hit_count         out  CNT    saturating count of cache hits
//   miss_count        out  CNT    saturating count of cache misses
// BEHAVIOUR
//   Reset values
//     - fetcher_state=IDLE, mem_read_valid=0, mem_read_address=0, instruction=0.
//     - hit_count=0, miss_count=0; all cache valid bits cleared.
//   Address split
//     - idx = current_pc[log2(CACHE_LINES)-1:0]; tag = remaining upper PC bits.
//   IDLE, when core_state==FETCH
//     - Hit (valid[idx] && tag match): instruction<=line data; go to FETCHED next edge;
//       hit_count++. One-cycle latency; no memory request is issued.
//     - Miss: mem_read_valid<=1, mem_read_address<=current_pc; go to FETCHING; miss_count++.
//     - Any other core_state: stay IDLE with no outputs changing.
//   FETCHING
//     - mem_read_valid and mem_read_address are held stable until the edge where
//       mem_read_ready=1. current_pc changes are ignored after sampling.
//     - On ready: instruction<=mem_read_data, mem_read_valid<=0, line[idx] written
//       (valid=1, tag, data), go to FETCHED.
//     - Same-cycle ready is legal, giving a miss latency of 2 edges minimum.
//   FETCHED
//     - instruction is held.
//     - core_state==DECODE -> IDLE next edge; otherwise stay in FETCHED.
//   Boundary conditions
//     - mem_read_ready while mem_read_valid=0 is ignored; no fill and no state change.
//     - Reset mid-FETCHING drops the request (mem_read_valid=0 after the edge); a late
//       ready is then ignored. Reset clears the cache, so the next fetch misses.
//     - A miss to a line already valid with a different tag overwrites that line.
//     - Counters saturate at all-ones and do not wrap.
//     - PC wrap-around (0xFF -> 0x00) needs no special handling; idx/tag are pure bit slices.
//   No lookup and fill coincide, since lookup happens only in IDLE and fill only in FETCHING.
// STRUCTURE
//   Shared package gpu_pkg holds:
//     - fetcher_state_t enum (IDLE/FETCHING/FETCHED), matching the scheduler's encoding
//     - core_state constants CORE_FETCH, CORE_DECODE
//   Sub-module icache_array:
//     - valid/tag/data storage with combinational lookup (hit, data)
//     - synchronous single-line write and synchronous clear-all on reset
//   The top level holds the 3-state FSM, the request registers and the counters.
// TESTING
//   1. Reset, core_state=FETCH, pc=0x05, ready after 3 cycles with data=0x1234
//      -> FETCHING with valid=1, addr=0x05 held; then FETCHED, instruction=0x1234,
//      miss_count=1.
//   2. DECODE, then FETCH again with pc=0x05 -> no mem_read_valid; FETCHED one edge
//      after FETCH, instruction=0x1234, hit_count=1.
//   3. pc=0x0D (same idx 5, different tag), data=0xABCD -> miss, line replaced;
//      a following pc=0x05 fetch misses again; miss_count=3.
//   4. Assert reset while FETCHING -> mem_read_valid=0 and state IDLE after the edge;
//      ready pulsed next cycle has no effect; refetch of pc=0x05 misses.
//   5. Hold FETCHED for 4 cycles with core_state=FETCH -> instruction stable;
//      DECODE -> IDLE.
//   6. Preload hit_count to all-ones by repeated hits -> the next hit keeps it at 0xFFFF.

Source files
------------

// File: rtl/gpu_pkg.sv
// gpu_pkg: encodings shared by the fetcher and the scheduler.
package gpu_pkg;
   typedef enum logic [2:0] {
      IDLE     = 3'b000,
      FETCHING = 3'b001,
      FETCHED  = 3'b010
   } fetcher_state_t;
   localparam logic [2:0] CORE_FETCH  = 3'b001;
   localparam logic [2:0] CORE_DECODE = 3'b010;
endpackage

// File: rtl/icache_array.sv
// icache_array: direct-mapped instruction cache, one instruction per line,
// combinational lookup, synchronous fill and synchronous clear of all valid bits.
module icache_array #(
   parameter int ADDR_BITS = 8,
   parameter int DATA_BITS = 16,
   parameter int LINES     = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [ADDR_BITS-1:0] i_lookup_addr,
   output logic                 o_hit,
   output logic [DATA_BITS-1:0] o_data,
   input  logic                 i_wr_en,
   input  logic [ADDR_BITS-1:0] i_wr_addr,
   input  logic [DATA_BITS-1:0] i_wr_data
);
   localparam int IDX_BITS = $clog2(LINES);
   localparam int TAG_BITS = ADDR_BITS - IDX_BITS;
   logic [LINES-1:0]     r_valid;
   logic [TAG_BITS-1:0]  r_tag  [LINES];
   logic [DATA_BITS-1:0] r_data [LINES];
   logic [IDX_BITS-1:0]  w_rd_idx;
   logic [IDX_BITS-1:0]  w_wr_idx;
   assign w_rd_idx = i_lookup_addr[IDX_BITS-1:0];
   assign w_wr_idx = i_wr_addr[IDX_BITS-1:0];
   assign o_hit    = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == i_lookup_addr[ADDR_BITS-1:IDX_BITS]);
   assign o_data   = r_data[w_rd_idx];
   always_ff @(posedge clk) begin
      if (reset) r_valid <= '0;
      else if (i_wr_en) r_valid[w_wr_idx] <= 1'b1;
   end
   // tag/data need no reset: they are only trusted behind a set valid bit
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_tag[w_wr_idx]  <= i_wr_addr[ADDR_BITS-1:IDX_BITS];
         r_data[w_wr_idx] <= i_wr_data;
      end
   end
endmodule

// File: rtl/instruction_fetcher.sv
// instruction_fetcher: cache-first instruction fetch with a valid/ready miss path
// and saturating hit/miss counters.
module instruction_fetcher
   import gpu_pkg::*;
#(
   parameter int PROGRAM_MEM_ADDR_BITS = 8,
   parameter int PROGRAM_MEM_DATA_BITS = 16,
   parameter int CACHE_LINES           = 8,
   parameter int COUNTER_BITS          = 16
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [2:0]                       core_state,
   input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
   output logic                             mem_read_valid,
   output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
   input  logic                             mem_read_ready,
   input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
   output logic [2:0]                       fetcher_state,
   output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
   output logic [COUNTER_BITS-1:0]          hit_count,
   output logic [COUNTER_BITS-1:0]          miss_count
);
   fetcher_state_t                   r_state, w_next;
   logic                             r_valid;
   logic [PROGRAM_MEM_ADDR_BITS-1:0] r_addr;
   logic [PROGRAM_MEM_DATA_BITS-1:0] r_instr;
   logic [COUNTER_BITS-1:0]          r_hits, r_misses;
   logic                             w_hit, w_lookup, w_fill;
   logic [PROGRAM_MEM_DATA_BITS-1:0] w_hit_data;
   icache_array #(
      .ADDR_BITS(PROGRAM_MEM_ADDR_BITS),
      .DATA_BITS(PROGRAM_MEM_DATA_BITS),
      .LINES    (CACHE_LINES)
   ) u_cache (
      .clk          (clk),
      .reset        (reset),
      .i_lookup_addr(current_pc),
      .o_hit        (w_hit),
      .o_data       (w_hit_data),
      .i_wr_en      (w_fill),
      .i_wr_addr    (r_addr),
      .i_wr_data    (mem_read_data)
   );
   // fills use the latched request address, so PC changes during a miss are ignored
   always_comb begin
      w_lookup = (r_state == IDLE) && (core_state == CORE_FETCH);
      w_fill   = (r_state == FETCHING) && mem_read_ready;
      w_next   = w_lookup ? (w_hit ? FETCHED : FETCHING)
               : w_fill ? FETCHED
               : ((r_state == FETCHED) && (core_state == CORE_DECODE)) ? IDLE
               : r_state;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_valid  <= 1'b0;
         r_addr   <= '0;
         r_instr  <= '0;
         r_hits   <= '0;
         r_misses <= '0;
      end else begin
         r_state <= w_next;
         if (w_lookup && w_hit) begin
            r_instr <= w_hit_data;
            r_hits  <= r_hits + {{(COUNTER_BITS-1){1'b0}}, ~&r_hits};
         end
         if (w_lookup && !w_hit) begin
            r_valid  <= 1'b1;
            r_addr   <= current_pc;
            r_misses <= r_misses + {{(COUNTER_BITS-1){1'b0}}, ~&r_misses};
         end
         if (w_fill) begin
            r_instr <= mem_read_data;
            r_valid <= 1'b0;
         end
      end
   end
   assign mem_read_valid   = r_valid;
   assign mem_read_address = r_addr;
   assign fetcher_state    = r_state;
   assign instruction      = r_instr;
   assign hit_count        = r_hits;
   assign miss_count       = r_misses;
endmodule

// File: tb/tb_instruction_fetcher.sv
// tb_instruction_fetcher: scenario tasks with a scoreboard of expected instructions.
module tb_instruction_fetcher;
   import gpu_pkg::*;
   localparam int CB = 6;
   localparam logic [CB-1:0] CMAX = '1;
   logic        clk = 0, reset = 0, mem_read_valid, mem_read_ready = 0;
   logic [2:0]  core_state = 3'b000, fetcher_state;
   logic [7:0]  current_pc = 0, mem_read_address;
   logic [15:0] mem_read_data = 0, instruction;
   logic [CB-1:0] hit_count, miss_count;
   int n_cmp = 0, n_err = 0;
   logic [15:0] exp_q[$];
   instruction_fetcher #(.COUNTER_BITS(CB)) dut (
      .clk(clk), .reset(reset), .core_state(core_state), .current_pc(current_pc),
      .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
      .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
      .fetcher_state(fetcher_state), .instruction(instruction),
      .hit_count(hit_count), .miss_count(miss_count));
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   // drives one fetch; a miss is served after lat idle cycles with the PC scrambled meanwhile
   task automatic fetch(input logic [7:0] pc, input logic [15:0] data, input int lat,
                        output bit miss, output bit held);
      core_state = CORE_FETCH;
      current_pc = pc;
      tick();
      miss = (fetcher_state == FETCHING);
      held = mem_read_valid === 1'b1 && mem_read_address === pc;
      if (miss) begin
         current_pc = pc ^ 8'h5A;
         for (int i = 0; i < lat; i++) begin
            tick();
            if (!(mem_read_valid === 1'b1 && mem_read_address === pc && fetcher_state == FETCHING)) held = 0;
         end
         mem_read_ready = 1;
         mem_read_data  = data;
         tick();
         mem_read_ready = 0;
         mem_read_data  = 16'($urandom);
      end
   endtask
   task automatic release_fetch();
      core_state = CORE_DECODE;
      tick();
      core_state = 3'b000;
   endtask
   task automatic check_pop(input string name);
      logic [15:0] e;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_err++; $display("FAIL %s: scoreboard empty, got %h", name, instruction);
      end else begin
         e = exp_q.pop_front();
         if (fetcher_state !== FETCHED || instruction !== e) begin
            n_err++; $display("FAIL %s: state %b instr %h, want state 010 instr %h", name, fetcher_state, instruction, e);
         end
      end
   endtask
   task automatic test_reset();
      reset = 1; tick(); tick(); reset = 0;
      n_cmp++;
      if (fetcher_state !== IDLE || mem_read_valid !== 0 || mem_read_address !== 0 || instruction !== 0 || hit_count !== 0 || miss_count !== 0) begin
         n_err++; $display("FAIL reset: st %b v %b a %h i %h h %0d m %0d, want all zero", fetcher_state, mem_read_valid, mem_read_address, instruction, hit_count, miss_count);
      end
      core_state = CORE_DECODE; mem_read_ready = 1; tick(); tick(); mem_read_ready = 0; core_state = 0;
      n_cmp++;
      if (fetcher_state !== IDLE || mem_read_valid !== 0 || instruction !== 0) begin
         n_err++; $display("FAIL idle_quiet: st %b v %b i %h, want IDLE 0 0000", fetcher_state, mem_read_valid, instruction);
      end
   endtask
   task automatic test_miss();
      bit miss, held;
      exp_q.push_back(16'h1234);
      fetch(8'h05, 16'h1234, 3, miss, held);
      n_cmp++;
      if (!miss || !held) begin n_err++; $display("FAIL miss_req: miss %b held %b, want 1 1", miss, held); end
      check_pop("miss_data");
      n_cmp++;
      if (miss_count !== 1 || hit_count !== 0 || mem_read_valid !== 0) begin
         n_err++; $display("FAIL miss_cnt: m %0d h %0d v %b, want 1 0 0", miss_count, hit_count, mem_read_valid);
      end
   endtask
   task automatic test_hit();
      bit miss, held;
      release_fetch();
      n_cmp++;
      if (fetcher_state !== IDLE) begin n_err++; $display("FAIL decode_idle: st %b, want 000", fetcher_state); end
      exp_q.push_back(16'h1234);
      fetch(8'h05, 16'hDEAD, 0, miss, held);
      n_cmp++;
      if (miss || mem_read_valid !== 0 || hit_count !== 1) begin
         n_err++; $display("FAIL hit: miss %b v %b h %0d, want 0 0 1", miss, mem_read_valid, hit_count);
      end
      check_pop("hit_data");
   endtask
   task automatic test_conflict();
      bit miss, held;
      release_fetch();
      exp_q.push_back(16'hABCD);
      fetch(8'h0D, 16'hABCD, 0, miss, held);
      n_cmp++;
      if (!miss || !held) begin n_err++; $display("FAIL conflict_miss: miss %b held %b, want 1 1", miss, held); end
      check_pop("conflict_data");
      release_fetch();
      exp_q.push_back(16'h5555);
      fetch(8'h05, 16'h5555, 1, miss, held);
      check_pop("evicted_data");
      n_cmp++;
      if (!miss || miss_count !== 3 || hit_count !== 1) begin
         n_err++; $display("FAIL evict: miss %b m %0d h %0d, want 1 3 1", miss, miss_count, hit_count);
      end
   endtask
   task automatic test_reset_mid_fetch();
      bit miss, held;
      release_fetch();
      core_state = CORE_FETCH; current_pc = 8'h22; tick();
      core_state = 0; reset = 1; tick(); reset = 0;
      n_cmp++;
      if (fetcher_state !== IDLE || mem_read_valid !== 0) begin
         n_err++; $display("FAIL reset_drop: st %b v %b, want 000 0", fetcher_state, mem_read_valid);
      end
      mem_read_ready = 1; mem_read_data = 16'hBEEF; tick(); mem_read_ready = 0;
      n_cmp++;
      if (fetcher_state !== IDLE || instruction !== 0) begin
         n_err++; $display("FAIL late_ready: st %b i %h, want 000 0000", fetcher_state, instruction);
      end
      exp_q.push_back(16'h7777);
      fetch(8'h05, 16'h7777, 2, miss, held);
      n_cmp++;
      if (!miss || miss_count !== 1 || hit_count !== 0) begin
         n_err++; $display("FAIL cleared: miss %b m %0d h %0d, want 1 1 0", miss, miss_count, hit_count);
      end
      check_pop("refetch_data");
   endtask
   task automatic test_hold();
      bit ok = 1;
      for (int i = 0; i < 4; i++) begin
         mem_read_ready = 1'($urandom); mem_read_data = 16'($urandom); current_pc = 8'($urandom);
         tick();
         if (fetcher_state !== FETCHED || instruction !== 16'h7777) ok = 0;
      end
      mem_read_ready = 0;
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL hold: st %b i %h, want 010 7777", fetcher_state, instruction); end
      release_fetch();
      n_cmp++;
      if (fetcher_state !== IDLE || instruction !== 16'h7777) begin
         n_err++; $display("FAIL hold_exit: st %b i %h, want 000 7777", fetcher_state, instruction);
      end
   endtask
   task automatic test_saturation();
      bit miss, held;
      for (int i = 0; i < int'(CMAX); i++) begin
         fetch(8'h05, 16'h0, 0, miss, held);
         release_fetch();
      end
      n_cmp++;
      if (hit_count !== CMAX) begin n_err++; $display("FAIL preload: h %0d, want %0d", hit_count, CMAX); end
      exp_q.push_back(16'h7777);
      fetch(8'h05, 16'h0, 0, miss, held);
      check_pop("sat_data");
      n_cmp++;
      if (miss || hit_count !== CMAX || miss_count !== 1) begin
         n_err++; $display("FAIL saturate: miss %b h %0d m %0d, want 0 %0d 1", miss, hit_count, miss_count, CMAX);
      end
      release_fetch();
   endtask
   initial begin
      test_reset();
      test_miss();
      test_hit();
      test_conflict();
      test_reset_mid_fetch();
      test_hold();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
